// File: rtl/m7s_cdc_pkg.sv
// Shared constants for the m7s CDC request arbiter: FSM encoding and counter width.
package m7s_cdc_pkg;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_WAIT = 2'd1;
    localparam state_t ST_DONE = 2'd2;

    localparam int unsigned CNT_W = 16;

endpackage

// File: rtl/m7s_sync_ack_hi.sv
// Two-flop single-bit synchronizer, asynchronous active-high reset to 0.
module m7s_sync_ack_hi (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    // Capture the asynchronous input, then re-register to settle metastability.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/m7s_cdc_req_arb.sv
// Source-side controller sharing one toggle-handshake CDC channel among NREQ
// requesters with round-robin arbitration and an acknowledge timeout.
module m7s_cdc_req_arb
    import m7s_cdc_pkg::*;
#(
    parameter int unsigned NREQ    = 4,
    parameter int unsigned DW      = 8,
    parameter int unsigned IDW     = 2,
    parameter int unsigned TMO_CYC = 255
) (
    input  logic               src_clk,
    input  logic               src_rst,
    input  logic [NREQ-1:0]    req,
    input  logic [NREQ*DW-1:0] req_dat,
    output logic [NREQ-1:0]    gnt,
    output logic               tmo_err,
    output logic               busy,
    output logic               xfer_req,
    output logic [DW-1:0]      xfer_dat,
    output logic [IDW-1:0]     xfer_id,
    input  logic               xfer_ack
);

    localparam logic [CNT_W-1:0] TMO_LIM = CNT_W'(TMO_CYC);
    localparam logic [IDW-1:0]   LAST_ID = IDW'(NREQ - 1);

    state_t           state;
    logic [IDW-1:0]   ptr;
    logic [CNT_W-1:0] cnt;
    logic             ack_sync;
    logic [IDW-1:0]   sel;

    // First requester at or above the pointer, searching upward with wrap.
    function automatic logic [IDW-1:0] rr_pick(input logic [NREQ-1:0] r,
                                               input logic [IDW-1:0]  p);
        logic [IDW-1:0] res;
        logic           found;
        int unsigned    idx;
        res   = '0;
        found = 1'b0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            idx = (int'(p) + i) % NREQ;
            if (!found && r[idx]) begin
                res   = IDW'(idx);
                found = 1'b1;
            end
        end
        return res;
    endfunction

    m7s_sync_ack_hi u_sync_ack (
        .clk (src_clk),
        .rst (src_rst),
        .d   (xfer_ack),
        .q   (ack_sync)
    );

    // Combinational round-robin choice, only consumed in IDLE.
    always_comb begin
        sel = rr_pick(req, ptr);
    end

    // Handshake FSM with payload latch, timeout counter and pointer update.
    always_ff @(posedge src_clk or posedge src_rst) begin
        if (src_rst) begin
            state    <= ST_IDLE;
            ptr      <= '0;
            cnt      <= '0;
            tmo_err  <= 1'b0;
            xfer_req <= 1'b0;
            xfer_dat <= '0;
            xfer_id  <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (|req) begin
                        xfer_dat <= req_dat[int'(sel)*DW +: DW];
                        xfer_id  <= sel;
                        xfer_req <= ~xfer_req;
                        cnt      <= '0;
                        state    <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (cnt != '1) begin
                        cnt <= cnt + 1'b1;
                    end
                    if (ack_sync == xfer_req) begin
                        state <= ST_DONE;
                    end else if (cnt >= TMO_LIM) begin
                        // Abort but still complete so the requester is released.
                        tmo_err <= 1'b1;
                        state   <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    ptr   <= (xfer_id == LAST_ID) ? '0 : xfer_id + 1'b1;
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // Completion pulse and busy flag decoded from registered state.
    always_comb begin
        gnt  = '0;
        busy = (state != ST_IDLE);
        if (state == ST_DONE) begin
            for (int unsigned i = 0; i < NREQ; i++) begin
                gnt[i] = (xfer_id == IDW'(i));
            end
        end
    end

endmodule

// File: tb/tb_m7s_cdc_req_arb.sv
// Self-checking bench for m7s_cdc_req_arb: vector table plus directed corner sequences.
module tb_m7s_cdc_req_arb;

    logic        src_clk = 1'b0;
    logic        src_rst = 1'b1;
    logic [3:0]  req     = '0;
    logic [31:0] req_dat = '0;
    logic [3:0]  gnt;
    logic        tmo_err;
    logic        busy;
    logic        xfer_req;
    logic [7:0]  xfer_dat;
    logic [1:0]  xfer_id;
    logic        xfer_ack = 1'b0;
    logic        ack_en   = 1'b0;

    int total = 0;
    int bad   = 0;
    logic exp_tog = 1'b0;

    typedef struct {
        logic [3:0]  rq;
        logic [31:0] dat;
        int          id;
        logic [7:0]  edat;
    } vec_t;

    vec_t vecs[7];
    int   rr_order[5];

    m7s_cdc_req_arb #(
        .NREQ    (4),
        .DW      (8),
        .IDW     (2),
        .TMO_CYC (16)
    ) dut (
        .src_clk  (src_clk),
        .src_rst  (src_rst),
        .req      (req),
        .req_dat  (req_dat),
        .gnt      (gnt),
        .tmo_err  (tmo_err),
        .busy     (busy),
        .xfer_req (xfer_req),
        .xfer_dat (xfer_dat),
        .xfer_id  (xfer_id),
        .xfer_ack (xfer_ack)
    );

    always #5 src_clk = ~src_clk;

    // Destination model: echoes the request toggle shortly after each edge.
    always @(posedge src_clk) begin
        #2;
        if (src_rst) xfer_ack = 1'b0;
        else if (ack_en) xfer_ack = xfer_req;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got running want finished");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    // Counts negedges until a grant appears, bounded.
    task automatic wait_gnt(output int lat);
        lat = 0;
        forever begin
            @(negedge src_clk);
            lat++;
            if (gnt != 4'b0 || lat >= 100) break;
        end
    endtask

    task automatic do_reset();
        src_rst = 1'b1;
        req     = '0;
        ack_en  = 1'b0;
        repeat (2) @(negedge src_clk);
        src_rst = 1'b0;
        exp_tog = 1'b0;
    endtask

    task automatic run_xfer(input logic [3:0] rq, input logic [31:0] dat, input int id,
                            input logic [7:0] edat);
        int lat;
        req     = rq;
        req_dat = dat;
        wait_gnt(lat);
        exp_tog = ~exp_tog;
        check("xfer_latency", lat, 4);
        check("xfer_gnt", {28'b0, gnt}, 32'(1) << id);
        check("xfer_id", {30'b0, xfer_id}, id);
        check("xfer_dat", {24'b0, xfer_dat}, {24'b0, edat});
        check("xfer_req_tog", {31'b0, xfer_req}, {31'b0, exp_tog});
        req = '0;
        @(negedge src_clk);
        check("gnt_one_cycle", {28'b0, gnt}, 0);
        check("idle_not_busy", {31'b0, busy}, 0);
    endtask

    initial begin
        int lat;
        int k;

        vecs[0] = '{4'b0001, 32'h0000_00A5, 0, 8'hA5};
        vecs[1] = '{4'b0011, 32'h0000_7E5B, 1, 8'h7E};
        vecs[2] = '{4'b0011, 32'h0000_3C99, 0, 8'h99};
        vecs[3] = '{4'b1000, 32'hF000_0000, 3, 8'hF0};
        vecs[4] = '{4'b1010, 32'h1234_5678, 1, 8'h56};
        vecs[5] = '{4'b0100, 32'h00C3_0000, 2, 8'hC3};
        vecs[6] = '{4'b0101, 32'h00AB_00CD, 0, 8'hCD};
        rr_order = '{0, 1, 2, 3, 0};

        // Reset state.
        repeat (2) @(negedge src_clk);
        check("rst_gnt", {28'b0, gnt}, 0);
        check("rst_busy", {31'b0, busy}, 0);
        check("rst_xfer_req", {31'b0, xfer_req}, 0);
        check("rst_tmo_err", {31'b0, tmo_err}, 0);
        check("rst_xfer_dat", {24'b0, xfer_dat}, 0);
        check("rst_xfer_id", {30'b0, xfer_id}, 0);
        src_rst = 1'b0;
        ack_en  = 1'b1;
        @(negedge src_clk);

        // Vector table: single transfers exercising pointer wrap and priority.
        for (int i = 0; i < 7; i++) begin
            run_xfer(vecs[i].rq, vecs[i].dat, vecs[i].id, vecs[i].edat);
        end

        // All four requesting continuously: strict rotation from pointer 0.
        do_reset();
        ack_en  = 1'b1;
        req     = 4'b1111;
        req_dat = 32'h4433_2211;
        k = 0;
        for (int c = 0; c < 100; c++) begin
            @(negedge src_clk);
            if (gnt != 4'b0) begin
                check("rr_gnt", {28'b0, gnt}, 32'(1) << rr_order[k]);
                check("rr_dat", {24'b0, xfer_dat}, 32'h11 * (rr_order[k] + 1));
                k++;
                if (k == 5) begin
                    req = '0;
                    break;
                end
            end
        end
        check("rr_count", k, 5);
        @(negedge src_clk);

        // req[1] drops mid-WAIT and its payload changes: transfer still completes.
        req     = 4'b0110;
        req_dat = 32'h00BB_AA00;
        @(negedge src_clk);
        check("drop_busy", {31'b0, busy}, 1);
        req_dat = 32'h00BB_5500;
        req     = 4'b0100;
        wait_gnt(lat);
        check("drop_gnt", {28'b0, gnt}, 32'h2);
        check("drop_dat", {24'b0, xfer_dat}, 32'hAA);
        wait_gnt(lat);
        check("next_gnt", {28'b0, gnt}, 32'h4);
        check("next_dat", {24'b0, xfer_dat}, 32'hBB);
        req = '0;
        @(negedge src_clk);

        // Acknowledge never returns: timeout after the counter reaches 16.
        ack_en  = 1'b0;
        req     = 4'b0100;
        req_dat = 32'h0077_0000;
        lat = 0;
        forever begin
            @(negedge src_clk);
            lat++;
            if (gnt != 4'b0 || tmo_err || lat >= 100) break;
        end
        check("tmo_latency", lat, 18);
        check("tmo_err_set", {31'b0, tmo_err}, 1);
        check("tmo_gnt", {28'b0, gnt}, 32'h4);
        req = '0;
        @(negedge src_clk);
        check("tmo_idle", {31'b0, busy}, 0);
        check("tmo_gnt_once", {28'b0, gnt}, 0);
        check("tmo_sticky", {31'b0, tmo_err}, 1);

        // Reset three cycles into WAIT: immediate clear, no grant.
        do_reset();
        check("rst2_tmo_clr", {31'b0, tmo_err}, 0);
        req     = 4'b0010;
        req_dat = 32'h0000_5A00;
        repeat (3) @(negedge src_clk);
        check("mid_busy", {31'b0, busy}, 1);
        src_rst = 1'b1;
        #1;
        check("mid_rst_gnt", {28'b0, gnt}, 0);
        check("mid_rst_busy", {31'b0, busy}, 0);
        check("mid_rst_xreq", {31'b0, xfer_req}, 0);
        check("mid_rst_xdat", {24'b0, xfer_dat}, 0);
        check("mid_rst_xid", {30'b0, xfer_id}, 0);
        check("mid_rst_tmo", {31'b0, tmo_err}, 0);
        req = '0;
        for (int c = 0; c < 3; c++) begin
            @(negedge src_clk);
            check("mid_rst_no_gnt", {28'b0, gnt}, 0);
        end
        src_rst = 1'b0;
        ack_en  = 1'b1;
        exp_tog = 1'b0;
        run_xfer(4'b0010, 32'h0000_5A00, 1, 8'h5A);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
